// File: rtl/controlador_salidas.sv
// controlador_salidas: binary-to-BCD conversion (shift-and-add-3) and
// four-digit multiplexed seven-segment drive with overflow indication.
module controlador_salidas #(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [13:0] valor,
   output logic        busy,
   output logic        listo,
   output logic        desborde,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        dp
);

   localparam int unsigned VAL_W = 14;
   localparam int unsigned BCD_W = 20;
   localparam int unsigned DSP_W = 16;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned REF_W = $clog2(REFRESH_DIV);

   typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [VAL_W-1:0]   shift_q, shift_d;
   logic [BCD_W-1:0]   scratch_q, scratch_d, scratch_adj;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DSP_W-1:0]   disp_q, disp_d;
   logic               desborde_q, desborde_d;
   logic               listo_q, listo_d;
   logic               busy_q, busy_d;
   logic [REF_W-1:0]   ref_q, ref_d;
   logic [1:0]         idx_q, idx_d;
   logic [3:0]         digit;
   logic               blank;

   // Add 3 to every BCD nibble that is 5 or more before the next shift
   always_comb begin
      scratch_adj = scratch_q;
      for (int i = 0; i < 5; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5)
            scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
   end

   // Conversion FSM and refresh counter next-state logic
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      disp_d     = disp_q;
      desborde_d = desborde_q;
      listo_d    = 1'b0;
      busy_d     = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               shift_d   = valor;
               scratch_d = '0;
               cnt_d     = CNT_W'(VAL_W);
               state_d   = S_CONVERT;
            end
         end
         S_CONVERT: begin
            {scratch_d, shift_d} = {scratch_adj[BCD_W-2:0], shift_q, 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
               state_d = S_DONE;
         end
         S_DONE: begin
            disp_d     = scratch_q[DSP_W-1:0];
            desborde_d = (scratch_q[BCD_W-1:DSP_W] != 4'd0);
            listo_d    = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
         ref_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         ref_d = ref_q + REF_W'(1);
         idx_d = idx_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         disp_q     <= '0;
         desborde_q <= 1'b0;
         listo_q    <= 1'b0;
         busy_q     <= 1'b0;
         ref_q      <= '0;
         idx_q      <= '0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         scratch_q  <= scratch_d;
         cnt_q      <= cnt_d;
         disp_q     <= disp_d;
         desborde_q <= desborde_d;
         listo_q    <= listo_d;
         busy_q     <= busy_d;
         ref_q      <= ref_d;
         idx_q      <= idx_d;
      end
   end

   // Digit select, leading-zero blanking and segment decode
   always_comb begin
      digit = 4'd0;
      blank = 1'b0;
      case (idx_q)
         2'd0: digit = disp_q[3:0];
         2'd1: begin
            digit = disp_q[7:4];
            blank = (disp_q[15:4] == 12'd0);
         end
         2'd2: begin
            digit = disp_q[11:8];
            blank = (disp_q[15:8] == 8'd0);
         end
         default: begin
            digit = disp_q[15:12];
            blank = (disp_q[15:12] == 4'd0);
         end
      endcase

      an = ~(4'b0001 << idx_q);

      if (desborde_q) begin
         seg = 7'b0111111;
      end else if (blank) begin
         seg = 7'b1111111;
      end else begin
         case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
         endcase
      end
   end

   assign busy     = busy_q;
   assign listo    = listo_q;
   assign desborde = desborde_q;
   assign dp       = 1'b1;

endmodule

// File: tb/tb_controlador_salidas.sv
// Bench for controlador_salidas: scoreboard of started values checked on listo,
// then the multiplexed display is scanned against a decimal model.
module tb_controlador_salidas;

   localparam int unsigned RD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [13:0] valor = '0;
   logic        busy, listo, desborde, dp;
   logic [6:0]  seg;
   logic [3:0]  an;

   int n_total = 0;
   int n_bad   = 0;
   int prev_val = 0;
   int exp_q[$];

   controlador_salidas #(.REFRESH_DIV(RD)) dut (
      .clk(clk), .rst(rst), .start(start), .valor(valor),
      .busy(busy), .listo(listo), .desborde(desborde),
      .seg(seg), .an(an), .dp(dp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] code(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   function automatic int pow10(input int d);
      case (d)
         0: return 1;
         1: return 10;
         2: return 100;
         default: return 1000;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg(input int v, input int d);
      if (v > 9999) return 7'b0111111;
      if (d > 0 && v < pow10(d)) return 7'b1111111;
      return code((v / pow10(d)) % 10);
   endfunction

   function automatic int an_to_idx(input logic [3:0] a);
      case (a)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   // Scan 4 full digit periods: check every digit, step order, run length, no stray listo
   task automatic scan(input int v);
      int prev = -1;
      int run = 0;
      bit had_change = 0;
      int extra = 0;
      int idx;
      for (int k = 0; k < 4 * RD; k++) begin
         @(negedge clk);
         if (listo) extra++;
         idx = an_to_idx(an);
         if (idx < 0) begin
            chk("an_onehot", 32'(an), 32'(4'b1110));
         end else begin
            chk($sformatf("seg_v%0d_d%0d", v, idx), 32'(seg), 32'(exp_seg(v, idx)));
            if (idx != prev) begin
               if (prev >= 0) begin
                  chk("an_step", 32'(idx), 32'((prev + 1) % 4));
                  if (had_change) chk("an_run", 32'(run), 32'(RD));
                  had_change = 1;
               end
               run = 1;
               prev = idx;
            end else begin
               run++;
            end
         end
      end
      chk("extra_listo", 32'(extra), 32'd0);
   endtask

   // Start one conversion, optionally pulse start again during CONVERT and DONE
   task automatic do_conv(input int v, input bit inject);
      int cnt = 0;
      bit got = 0;
      int ev;
      int idx;
      @(negedge clk);
      start = 1'b1;
      valor = 14'(v);
      @(posedge clk);
      exp_q.push_back(v);
      #1 start = 1'b0;
      while (cnt < 40 && !got) begin
         @(posedge clk);
         cnt++;
         #1 start = 1'b0;
         @(negedge clk);
         if (cnt == 1) chk("busy_rise", 32'(busy), 32'd1);
         if (cnt == 7) begin
            idx = an_to_idx(an);
            if (idx >= 0) chk("hold_seg", 32'(seg), 32'(exp_seg(prev_val, idx)));
            chk("hold_desb", 32'(desborde), 32'(prev_val > 9999));
         end
         if (listo) begin
            got = 1;
            chk("latency", 32'(cnt), 32'd15);
            chk("busy_done", 32'(busy), 32'd1);
            if (exp_q.size() == 0) begin
               chk("sb_empty", 32'd1, 32'(exp_q.size()));
            end else begin
               ev = exp_q.pop_front();
               chk($sformatf("desborde_v%0d", ev), 32'(desborde), 32'(ev > 9999));
               prev_val = ev;
            end
         end
         if (inject && (cnt == 4 || cnt == 14)) begin
            start = 1'b1;
            valor = 14'd4321;
         end
      end
      if (!got) chk("listo_timeout", 32'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("busy_fall", 32'(busy), 32'd0);
      chk("listo_pulse", 32'(listo), 32'd0);
      scan(prev_val);
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_an"}, 32'(an), 32'(4'b1110));
      chk({tag, "_seg"}, 32'(seg), 32'(7'b1000000));
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_listo"}, 32'(listo), 32'd0);
      chk({tag, "_desb"}, 32'(desborde), 32'd0);
   endtask

   initial begin
      int cnt;
      int seen;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outs("rst");
      chk("dp", 32'(dp), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      prev_val = 0;

      do_conv(1234, 0);
      do_conv(9999, 0);
      do_conv(10000, 0);
      do_conv(16383, 0);
      do_conv(7, 0);
      do_conv(305, 0);
      do_conv(2468, 1);

      // Reset in the middle of a conversion
      @(negedge clk);
      start = 1'b1;
      valor = 14'd5678;
      @(posedge clk);
      exp_q.push_back(5678);
      #1 start = 1'b0;
      cnt = 0;
      repeat (7) begin
         @(posedge clk);
         cnt++;
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outs("rst_mid");
      exp_q.delete();
      prev_val = 0;
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (listo) seen++;
      end
      chk("abort_no_listo", 32'(seen), 32'd0);
      scan(0);
      do_conv(42, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
